// File: rtl/proc_pkg.sv
// Shared datapath types and constants for the processor register file.
// Default widths here size the convenience typedefs used outside parametrised blocks.
package proc_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    localparam int unsigned ZERO_REG = 0;

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;
    typedef logic [DW_DEFAULT-1:0] word_t;

endpackage

// File: rtl/reg_file_bypass_if.sv
// Register-file access bundle: one write port, NRD packed read ports and the busy-scoreboard controls.
// The master side is the pipeline (decode/writeback); the slave side is the register file.
interface reg_file_bypass_if
    import proc_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int AW  = AW_DEFAULT,
    parameter int NRD = 2
) ();

    logic                reg_write;
    logic [AW-1:0]       write_reg;
    logic [DW-1:0]       write_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                busy_set;
    logic [AW-1:0]       busy_reg;

    modport master (
        output reg_write, write_reg, write_data, rd_addr, busy_set, busy_reg,
        input  rd_data, rd_busy
    );

    modport slave (
        input  reg_write, write_reg, write_data, rd_addr, busy_set, busy_reg,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/rf_read_port.sv
// One read port: register-0 forcing, same-cycle write bypass and an optional output register.
// wr_en arrives already qualified (reset released, write_reg != 0).
module rf_read_port #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int REG_READ = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [AW-1:0] write_reg,
    input  logic [DW-1:0] write_data,
    input  logic [DW-1:0] mem_data,
    input  logic          mem_busy,
    output logic [DW-1:0] data,
    output logic          busy
);

    logic          hit;
    logic [DW-1:0] data_d;
    logic          busy_d;

    always_comb begin
        // NOTE: every output of this block gets a default before the if-chain so no path leaves a latch.
        hit    = wr_en && (write_reg == addr);
        data_d = mem_data;
        busy_d = mem_busy && !hit;
        if (addr == '0) begin
            data_d = '0;
        end else if (hit) begin
            data_d = write_data;
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data <= '0;
                    busy <= 1'b0;
                end else begin
                    data <= data_d;
                    busy <= busy_d;
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign data = data_d;
            assign busy = busy_d;
        end
    endgenerate

endmodule

// File: rtl/reg_file_bypass.sv
// Parametrised register file with per-port write bypass, optional registered reads and a
// per-register busy scoreboard for RAW hazard detection. Register 0 is constant zero and never busy.
module reg_file_bypass
    import proc_pkg::*;
#(
    parameter  int DW       = DW_DEFAULT,
    parameter  int NREG     = NREG_DEFAULT,
    parameter  int NRD      = 2,
    parameter  int REG_READ = 0,
    localparam int AW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_bypass_if.slave bus
);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;
    logic            wr_en;
    logic            set_en;

    // Gating with rst also suppresses the bypass while reset is held.
    assign wr_en  = rst && bus.reg_write && (bus.write_reg != AW'(ZERO_REG));
    assign set_en = bus.busy_set && (bus.busy_reg != AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is cleared in reset so every register reads 0 afterwards; this keeps it in flops, not a RAM macro.
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.write_reg] <= bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            // NOTE: non-blocking updates resolve last-wins, so the set below overrides a same-edge clear.
            if (wr_en) begin
                busy[bus.write_reg] <= 1'b0;
            end
            if (set_en) begin
                busy[bus.busy_reg] <= 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_port
            logic [AW-1:0] addr;
            assign addr = bus.rd_addr[k*AW +: AW];

            rf_read_port #(
                .DW       (DW),
                .AW       (AW),
                .REG_READ (REG_READ)
            ) u_port (
                .clk        (clk),
                .rst        (rst),
                .addr       (addr),
                .wr_en      (wr_en),
                .write_reg  (bus.write_reg),
                .write_data (bus.write_data),
                .mem_data   (mem[addr]),
                .mem_busy   (busy[addr]),
                .data       (bus.rd_data[k*DW +: DW]),
                .busy       (bus.rd_busy[k])
            );
        end
    endgenerate

endmodule
